// File: rtl/mv_decision_if.sv
// rtl/mv_decision_if.sv - bundle of search-input and result-output signals for mv_decision
// Ports (slave = decision block side):
//   search_start, search_done : window open/close pulses
//   sad_valid, sad, cb_sel, cand_col, cand_row : candidate SAD sample stream
//   mv_valid, mv_ready, mv_cb, mv_col, mv_row, mv_sad : per-sub-block result beats
//   busy, sad_drop : status
interface mv_decision_if #(
  parameter int SAD_W = 16
) ();
  logic             search_start;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;
  logic [1:0]       cb_sel;
  logic [4:0]       cand_col;
  logic [6:0]       cand_row;
  logic             search_done;
  logic             mv_ready;
  logic             mv_valid;
  logic [1:0]       mv_cb;
  logic [4:0]       mv_col;
  logic [6:0]       mv_row;
  logic [SAD_W-1:0] mv_sad;
  logic             busy;
  logic             sad_drop;

  modport master (
    output search_start, sad_valid, sad, cb_sel, cand_col, cand_row, search_done, mv_ready,
    input  mv_valid, mv_cb, mv_col, mv_row, mv_sad, busy, sad_drop
  );

  modport slave (
    input  search_start, sad_valid, sad, cb_sel, cand_col, cand_row, search_done, mv_ready,
    output mv_valid, mv_cb, mv_col, mv_row, mv_sad, busy, sad_drop
  );
endinterface

// File: rtl/mv_decision.sv
// rtl/mv_decision.sv - per-sub-block minimum-SAD motion vector decision
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mv_decision_if.slave (search control, SAD samples, result beats, status)
module mv_decision #(
  parameter int SAD_W = 16
) (
  input logic          clk,
  input logic          rst,
  mv_decision_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_REPORT} state_t;

  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  state_t           state_q, state_d;
  logic [SAD_W-1:0] min_sad_q  [4];
  logic [SAD_W-1:0] min_sad_d  [4];
  logic [4:0]       best_col_q [4];
  logic [4:0]       best_col_d [4];
  logic [6:0]       best_row_q [4];
  logic [6:0]       best_row_d [4];
  logic             mv_valid_q, mv_valid_d;
  logic [1:0]       mv_cb_q, mv_cb_d;
  logic [4:0]       mv_col_q, mv_col_d;
  logic [6:0]       mv_row_q, mv_row_d;
  logic [SAD_W-1:0] mv_sad_q, mv_sad_d;
  logic             busy_q, busy_d;
  logic             sad_drop_q, sad_drop_d;
  logic [1:0]       next_cb;

  assign next_cb = mv_cb_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    min_sad_d  = min_sad_q;
    best_col_d = best_col_q;
    best_row_d = best_row_q;
    mv_valid_d = mv_valid_q;
    mv_cb_d    = mv_cb_q;
    mv_col_d   = mv_col_q;
    mv_row_d   = mv_row_q;
    mv_sad_d   = mv_sad_q;
    sad_drop_d = sad_drop_q;

    case (state_q)
      S_IDLE: begin
        if (bus.search_start) begin
          state_d    = S_SEARCH;
          sad_drop_d = 1'b0;
          for (int i = 0; i < 4; i++) begin
            min_sad_d[i]  = SAD_MAX;
            best_col_d[i] = '0;
            best_row_d[i] = '0;
          end
        end
        // A stray sample is flagged even if it coincides with the opening pulse.
        if (bus.sad_valid) sad_drop_d = 1'b1;
      end

      S_SEARCH: begin
        if (bus.search_start) begin
          // Restart: any sample in this cycle belongs to the abandoned window.
          sad_drop_d = 1'b0;
          for (int i = 0; i < 4; i++) begin
            min_sad_d[i]  = SAD_MAX;
            best_col_d[i] = '0;
            best_row_d[i] = '0;
          end
        end else begin
          // Strict compare so equal SADs keep the earliest candidate.
          if (bus.sad_valid && (bus.sad < min_sad_q[bus.cb_sel])) begin
            min_sad_d[bus.cb_sel]  = bus.sad;
            best_col_d[bus.cb_sel] = bus.cand_col;
            best_row_d[bus.cb_sel] = bus.cand_row;
          end
          if (bus.search_done) begin
            // First beat is loaded from the _d arrays so a sample arriving
            // with search_done is already reflected in cb 0's result.
            state_d    = S_REPORT;
            mv_valid_d = 1'b1;
            mv_cb_d    = 2'd0;
            mv_col_d   = best_col_d[0];
            mv_row_d   = best_row_d[0];
            mv_sad_d   = min_sad_d[0];
          end
        end
      end

      S_REPORT: begin
        if (bus.sad_valid) sad_drop_d = 1'b1;
        if (mv_valid_q && bus.mv_ready) begin
          if (mv_cb_q == 2'd3) begin
            state_d    = S_IDLE;
            mv_valid_d = 1'b0;
          end else begin
            mv_cb_d  = next_cb;
            mv_col_d = best_col_q[next_cb];
            mv_row_d = best_row_q[next_cb];
            mv_sad_d = min_sad_q[next_cb];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        min_sad_q[i]  <= SAD_MAX;
        best_col_q[i] <= '0;
        best_row_q[i] <= '0;
      end
      mv_valid_q <= 1'b0;
      mv_cb_q    <= '0;
      mv_col_q   <= '0;
      mv_row_q   <= '0;
      mv_sad_q   <= '0;
      busy_q     <= 1'b0;
      sad_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_sad_q  <= min_sad_d;
      best_col_q <= best_col_d;
      best_row_q <= best_row_d;
      mv_valid_q <= mv_valid_d;
      mv_cb_q    <= mv_cb_d;
      mv_col_q   <= mv_col_d;
      mv_row_q   <= mv_row_d;
      mv_sad_q   <= mv_sad_d;
      busy_q     <= busy_d;
      sad_drop_q <= sad_drop_d;
    end
  end

  assign bus.mv_valid = mv_valid_q;
  assign bus.mv_cb    = mv_cb_q;
  assign bus.mv_col   = mv_col_q;
  assign bus.mv_row   = mv_row_q;
  assign bus.mv_sad   = mv_sad_q;
  assign bus.busy     = busy_q;
  assign bus.sad_drop = sad_drop_q;

endmodule

// File: tb/tb_mv_decision.sv
// tb/tb_mv_decision.sv - self-checking bench for mv_decision
module tb_mv_decision;
  localparam int SAD_W = 16;
  localparam logic [15:0] ALL1 = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mv_decision_if #(.SAD_W(SAD_W)) bus ();
  mv_decision #(.SAD_W(SAD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: window = list of samples ----------------
  typedef struct {
    logic [1:0]  cb;
    logic [4:0]  col;
    logic [6:0]  row;
    logic [15:0] sad;
  } samp_t;

  samp_t       win[$];
  int          m_state;   // 0 idle, 1 search, 2 report
  int          m_beat;
  bit          m_drop;
  bit          e_valid, e_busy;
  logic [1:0]  e_cb;
  logic [4:0]  e_col;
  logic [6:0]  e_row;
  logic [15:0] e_sad;

  // Best candidate of a sub-block: first sample holding the smallest SAD.
  function automatic samp_t best_of(input int cb);
    samp_t r;
    r.cb = 2'(cb); r.col = '0; r.row = '0; r.sad = ALL1;
    foreach (win[i]) if (win[i].cb == 2'(cb) && win[i].sad < r.sad) r = win[i];
    return r;
  endfunction

  function automatic void load_beat(input int b);
    samp_t r;
    r = best_of(b);
    m_beat = b; e_cb = 2'(b); e_col = r.col; e_row = r.row; e_sad = r.sad;
  endfunction

  function automatic void model_reset();
    m_state = 0; win.delete(); m_drop = 0; m_beat = 0;
    e_cb = '0; e_col = '0; e_row = '0; e_sad = '0;
  endfunction

  function automatic void model_step();
    samp_t s;
    s.cb = bus.cb_sel; s.col = bus.cand_col; s.row = bus.cand_row; s.sad = bus.sad;
    case (m_state)
      0: begin
        if (bus.search_start) begin win.delete(); m_drop = 0; m_state = 1; end
        if (bus.sad_valid) m_drop = 1;
      end
      1: begin
        if (bus.search_start) begin win.delete(); m_drop = 0; end
        else begin
          if (bus.sad_valid) win.push_back(s);
          if (bus.search_done) begin m_state = 2; load_beat(0); end
        end
      end
      default: begin
        if (bus.sad_valid) m_drop = 1;
        if (bus.mv_ready) begin
          if (m_beat == 3) m_state = 0;
          else load_beat(m_beat + 1);
        end
      end
    endcase
  endfunction

  always_comb begin
    e_valid = (m_state == 2);
    e_busy  = (m_state != 0);
  end

  task automatic drive(input bit st, input bit sv, input logic [15:0] sd, input logic [1:0] cb,
                       input logic [4:0] col, input logic [6:0] row, input bit dn, input bit rdy);
    bus.search_start = st; bus.sad_valid = sv; bus.sad = sd; bus.cb_sel = cb;
    bus.cand_col = col; bus.cand_row = row; bus.search_done = dn; bus.mv_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " valid"}, bus.mv_valid, e_valid);
    check({tag, " busy"},  bus.busy,     e_busy);
    check({tag, " drop"},  bus.sad_drop, m_drop);
    if (e_valid) begin
      check({tag, " cb"},  bus.mv_cb,  e_cb);
      check({tag, " col"}, bus.mv_col, e_col);
      check({tag, " row"}, bus.mv_row, e_row);
      check({tag, " sad"}, bus.mv_sad, e_sad);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st, sv; logic [15:0] sd; logic [1:0] cb; logic [4:0] col; logic [6:0] row; bit dn, rdy;
    bit ev; logic [1:0] ecb; logic [4:0] ecol; logic [6:0] erow; logic [15:0] esad; bit ebusy, edrop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit st, bit sv, logic [15:0] sd, logic [1:0] cb, logic [4:0] col,
                             logic [6:0] row, bit dn, bit rdy, bit ev, logic [1:0] ecb,
                             logic [4:0] ecol, logic [6:0] erow, logic [15:0] esad, bit ebusy, bit edrop);
    vec_t r;
    r.st = st; r.sv = sv; r.sd = sd; r.cb = cb; r.col = col; r.row = row; r.dn = dn; r.rdy = rdy;
    r.ev = ev; r.ecb = ecb; r.ecol = ecol; r.erow = erow; r.esad = esad; r.ebusy = ebusy; r.edrop = edrop;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", bus.mv_valid, 0);
    check("reset busy",  bus.busy, 0);
    check("reset sad",   bus.mv_sad, 0);
    rst = 1'b0;

    //            st sv sad   cb col row dn rdy  ev cb col row sad   busy drop
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0,   0, 0, 0, 0,  0,    0, 0)); // reset state
    tbl.push_back(v(1, 0, 0,    0, 0, 0,  0, 0,   0, 0, 0, 0,  0,    1, 0));
    tbl.push_back(v(0, 1, 500,  0, 3, 10, 0, 0,   0, 0, 0, 0,  0,    1, 0));
    tbl.push_back(v(0, 1, 200,  0, 5, 20, 0, 0,   0, 0, 0, 0,  0,    1, 0));
    tbl.push_back(v(0, 1, 200,  0, 6, 21, 0, 0,   0, 0, 0, 0,  0,    1, 0)); // tie keeps (5,20)
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 1,   1, 0, 5, 20, 200,  1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 1, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 2, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 3, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   0, 0, 0, 0,  0,    0, 0));
    tbl.push_back(v(0, 1, 10,   1, 4, 4,  0, 0,   0, 0, 0, 0,  0,    0, 1)); // sample in IDLE
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0,   0, 0, 0, 0,  0,    0, 1));
    tbl.push_back(v(1, 0, 0,    0, 0, 0,  0, 0,   0, 0, 0, 0,  0,    1, 0));
    tbl.push_back(v(0, 1, 10,   2, 1, 2,  1, 0,   1, 0, 0, 0,  ALL1, 1, 0)); // sample with done
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0,   1, 0, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 1, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(1, 0, 0,    0, 0, 0,  1, 0,   1, 1, 0, 0,  ALL1, 1, 0)); // ignored in REPORT
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0,   1, 1, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0,   1, 1, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 2, 1, 2,  10,   1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 3, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   0, 0, 0, 0,  0,    0, 0));
    tbl.push_back(v(1, 0, 0,    0, 0, 0,  0, 0,   0, 0, 0, 0,  0,    1, 0));
    tbl.push_back(v(0, 1, 50,   3, 7, 9,  0, 0,   0, 0, 0, 0,  0,    1, 0));
    tbl.push_back(v(1, 1, 40,   3, 8, 8,  0, 0,   0, 0, 0, 0,  0,    1, 0)); // restart discards 40
    tbl.push_back(v(1, 0, 0,    0, 0, 0,  1, 0,   0, 0, 0, 0,  0,    1, 0)); // start beats done
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 0,   1, 0, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 1, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 2, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   1, 3, 0, 0,  ALL1, 1, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 1,   0, 0, 0, 0,  0,    0, 0));
    tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 0,   0, 0, 0, 0,  0,    0, 0)); // done in IDLE

    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      drive(t.st, t.sv, t.sd, t.cb, t.col, t.row, t.dn, t.rdy);
      tick();
      check($sformatf("vec%0d valid", i), bus.mv_valid, t.ev);
      check($sformatf("vec%0d busy", i),  bus.busy,     t.ebusy);
      check($sformatf("vec%0d drop", i),  bus.sad_drop, t.edrop);
      if (t.ev || i == 0) begin
        check($sformatf("vec%0d cb", i),  bus.mv_cb,  t.ecb);
        check($sformatf("vec%0d col", i), bus.mv_col, t.ecol);
        check($sformatf("vec%0d row", i), bus.mv_row, t.erow);
        check($sformatf("vec%0d sad", i), bus.mv_sad, t.esad);
      end
    end

    // ---------------- reset in the middle of REPORT beat cb2 ----------------
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 30, 2, 1, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    tick();
    check("pre-rst cb", bus.mv_cb, 2);
    check("pre-rst sad", bus.mv_sad, 30);
    rst = 1'b1;
    #1;
    check("async rst valid", bus.mv_valid, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst cb", bus.mv_cb, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick(); compare_model("rst-seq");
    drive(0, 1, 77, 1, 2, 3, 0, 0); tick(); compare_model("rst-seq");
    drive(0, 0, 0, 0, 0, 0, 1, 1); tick(); compare_model("rst-seq");
    tick(); compare_model("rst-seq");
    check("fresh cb1 sad", bus.mv_sad, 77);
    tick(); compare_model("rst-seq");
    check("fresh cb2 sad", bus.mv_sad, ALL1);
    tick(); tick(); compare_model("rst-seq");

    // ---------------- randomized traffic against the model ----------------
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            16'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)),
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
      tick();
      compare_model($sformatf("rnd%0d", n));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mv_decision.md
MV_DECISION -- requirements
Module: mv_decision

Interface
REQ-001 Parameter SAD_W, default 16, SAD sample width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 search_start  input  1  one-cycle pulse; opens a new search window.
REQ-005 sad_valid  input  1  SAD sample present this cycle.
REQ-006 sad  input  SAD_W  candidate SAD, unsigned.
REQ-007 cb_sel  input  2  sub-block index 0..3 of the sample (same encoding as abs_Control).
REQ-008 cand_col  input  5  candidate search column (search_column_count).
REQ-009 cand_row  input  7  candidate search row (search_row_count).
REQ-010 search_done  input  1  one-cycle pulse; closes the window.
REQ-011 mv_ready  input  1  downstream accepts the current result.
REQ-012 mv_valid  output  1  result beat valid.
REQ-013 mv_cb  output  2  sub-block index of the result.
REQ-014 mv_col  output  5  best column.
REQ-015 mv_row  output  7  best row.
REQ-016 mv_sad  output  SAD_W  best SAD.
REQ-017 busy  output  1  high in SEARCH and REPORT.
REQ-018 sad_drop  output  1  sticky flag: a sad_valid was seen outside SEARCH.

Function
REQ-019 The block SHALL implement states IDLE, SEARCH, REPORT; all outputs are registered.
REQ-020 IDLE: search_start -> SEARCH next cycle; min_sad[0..3] set to all ones; best col/row[0..3] set to 0; sad_drop cleared.
REQ-021 SEARCH: when sad_valid and sad < min_sad[cb_sel] (strict), that entry SHALL take sad, cand_col, cand_row the next edge; ties keep the earlier candidate.
REQ-022 SEARCH: search_done -> REPORT next cycle; a sad_valid in the same cycle SHALL be compared before the window closes.
REQ-023 SEARCH: search_start restarts the window (reinit per REQ-020); a sad_valid in the same cycle is discarded.
REQ-024 Simultaneous search_start and search_done in SEARCH: search_start wins; state stays SEARCH.
REQ-025 REPORT: mv_valid SHALL rise in the first REPORT cycle, with mv_cb=0 and that entry's col/row/sad.
REQ-026 Each beat advances on mv_valid && mv_ready, in order cb 0,1,2,3; next beat presented the following cycle with no bubble.
REQ-027 While mv_valid && !mv_ready, all mv_* outputs SHALL stay stable.
REQ-028 Acceptance of cb 3 -> IDLE next cycle; mv_valid low.
REQ-029 A sub-block with no samples SHALL report mv_sad all ones and col=row=0.
REQ-030 sad_valid in IDLE or REPORT SHALL set sad_drop and not alter stored results.
REQ-031 search_start and search_done in REPORT are ignored.
REQ-032 search_done in IDLE is ignored.
REQ-033 busy=1 exactly when state is SEARCH or REPORT.

Reset
REQ-034 rst asserted at any time, including mid-SEARCH or mid-REPORT, SHALL immediately force IDLE.
REQ-035 Reset values: mv_valid=0, mv_cb=0, mv_col=0, mv_row=0, mv_sad=0, busy=0, sad_drop=0, min_sad all ones, best positions 0.
REQ-036 The first edge after rst deasserts SHALL behave as a normal IDLE cycle.

Verification
REQ-037 start; cb0 SADs 500@(3,10), 200@(5,20), 200@(6,21); done; mv_ready=1 -> beat cb0 reports col 5, row 20, sad 200, then cb1..3 report sad 0xFFFF.
REQ-038 Four beats with mv_ready low 3 cycles on beat cb1 -> cb1 outputs unchanged for those cycles; beats cb0..3 in order; IDLE after cb3.
REQ-039 sad_valid with sad 10 in the same cycle as search_done -> 10 is included in the reported minimum.
REQ-040 sad_valid in IDLE -> sad_drop=1 until next search_start; stored results unchanged.
REQ-041 rst pulse during REPORT beat cb2 -> mv_valid=0 and busy=0 immediately; a fresh search then reports only new samples.
REQ-042 search_start mid-SEARCH after cb3 sample 50 -> cb3 reports 0xFFFF if no later cb3 samples arrive.
